// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Largest value of a tens digit (minutes and seconds both stop at 5x).
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX     = 4'd9;

    // digit_blank masks: bit3 = mins_tens .. bit0 = secs_ones.
    localparam logic [3:0] BLANK_MINS = 4'b1100;
    localparam logic [3:0] BLANK_SECS = 4'b0011;
    localparam logic [3:0] BLANK_NONE = 4'b0000;

    // Scan index range: first digit driven (mins_tens) and last (secs_ones).
    localparam logic [1:0] SCAN_FIRST = 2'd0;
    localparam logic [1:0] SCAN_LAST  = 2'd3;

    // True when a BCD pair sits at 59, i.e. the next increment wraps.
    function automatic logic bcd_pair_at_max(input logic [3:0] tens,
                                             input logic [3:0] ones);
        return (tens == SEC_TENS_MAX) && (ones == ONES_MAX);
    endfunction

    // Increment a 00..59 BCD pair, wrapping 59 -> 00. Returns {tens, ones}.
    function automatic logic [7:0] bcd_pair_inc(input logic [3:0] tens,
                                                input logic [3:0] ones);
        logic [3:0] n_tens;
        logic [3:0] n_ones;
        if (ones == ONES_MAX) begin
            n_ones = 4'd0;
            if (tens == SEC_TENS_MAX) begin
                n_tens = 4'd0;
            end else begin
                n_tens = tens + 4'd1;
            end
        end else begin
            n_ones = ones + 4'd1;
            n_tens = tens;
        end
        return {n_tens, n_ones};
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_clk_div_tick.sv
// Tick divider: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
// While hold is high the count is parked at 0 and no tick is produced, so a
// released divider always needs a full DIV cycles before its first tick.
module clk_div_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    // Free-running modulo-DIV counter, parked at 0 while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (hold) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (r_cnt == LAST) && !hold;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD time, RUN/PAUSED/ADJUST mode machine,
// count/adjust/blink/scan tick generation for the display multiplexer.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int ONE_HZ_DIV = 100_000_000,
    parameter int ADJ_DIV    = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause_pulse,
    output logic [3:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [3:0] digit_blank,
    output logic       blink_on,
    output logic [1:0] scan_idx
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_paused;
    logic       w_paused_next;

    logic       w_tick_1hz;
    logic       w_tick_adj;
    logic       w_tick_blink;
    logic       w_tick_scan;
    logic       w_hold_1hz;
    logic       w_hold_adj;

    logic [3:0] r_mins_tens;
    logic [3:0] r_mins_ones;
    logic [3:0] r_secs_tens;
    logic [3:0] r_secs_ones;
    logic [7:0] w_secs_inc;
    logic [7:0] w_mins_inc;
    logic       w_secs_wrap;

    logic       r_blink_on;
    logic [1:0] r_scan_idx;
    logic [3:0] w_blank;

    assign w_hold_1hz = (r_state != RUN);
    assign w_hold_adj = (r_state != ADJUST);

    clk_div_tick #(.DIV(ONE_HZ_DIV)) u_div_1hz (
        .clk (clk),
        .rst (rst),
        .hold(w_hold_1hz),
        .tick(w_tick_1hz)
    );

    clk_div_tick #(.DIV(ADJ_DIV)) u_div_adj (
        .clk (clk),
        .rst (rst),
        .hold(w_hold_adj),
        .tick(w_tick_adj)
    );

    clk_div_tick #(.DIV(BLINK_DIV)) u_div_blink (
        .clk (clk),
        .rst (rst),
        .hold(1'b0),
        .tick(w_tick_blink)
    );

    clk_div_tick #(.DIV(SCAN_DIV)) u_div_scan (
        .clk (clk),
        .rst (rst),
        .hold(1'b0),
        .tick(w_tick_scan)
    );

    // Next mode: adj wins; otherwise the (already toggled) paused flag decides,
    // so a pause request lands on the very edge that samples it.
    always_comb begin
        w_paused_next = r_paused ^ pause_pulse;
        if (adj) begin
            w_state_next = ADJUST;
        end else if (w_paused_next) begin
            w_state_next = PAUSED;
        end else begin
            w_state_next = RUN;
        end
    end

    // Mode register and paused flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_paused <= w_paused_next;
        end
    end

    assign w_secs_inc  = bcd_pair_inc(r_secs_tens, r_secs_ones);
    assign w_mins_inc  = bcd_pair_inc(r_mins_tens, r_mins_ones);
    assign w_secs_wrap = bcd_pair_at_max(r_secs_tens, r_secs_ones);

    // Time digits: 1 Hz counting with carry in RUN, per-pair stepping in ADJUST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mins_tens <= 4'd0;
            r_mins_ones <= 4'd0;
            r_secs_tens <= 4'd0;
            r_secs_ones <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_tick_1hz) begin
                        {r_secs_tens, r_secs_ones} <= w_secs_inc;
                        if (w_secs_wrap) begin
                            {r_mins_tens, r_mins_ones} <= w_mins_inc;
                        end
                    end
                end
                ADJUST: begin
                    if (w_tick_adj) begin
                        if (sel) begin
                            {r_secs_tens, r_secs_ones} <= w_secs_inc;
                        end else begin
                            {r_mins_tens, r_mins_ones} <= w_mins_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Blink phase and display scan position, both free-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_on <= 1'b1;
            r_scan_idx <= SCAN_FIRST;
        end else begin
            if (w_tick_blink) begin
                r_blink_on <= ~r_blink_on;
            end
            if (w_tick_scan) begin
                if (r_scan_idx == SCAN_LAST) begin
                    r_scan_idx <= SCAN_FIRST;
                end else begin
                    r_scan_idx <= r_scan_idx + 2'd1;
                end
            end
        end
    end

    // Blank the pair being adjusted during the dark half of the blink phase.
    always_comb begin
        w_blank = BLANK_NONE;
        case (r_state)
            ADJUST: begin
                if (!r_blink_on) begin
                    w_blank = sel ? BLANK_SECS : BLANK_MINS;
                end else begin
                    w_blank = BLANK_NONE;
                end
            end
            default: w_blank = BLANK_NONE;
        endcase
    end

    assign mins_tens   = r_mins_tens;
    assign mins_ones   = r_mins_ones;
    assign secs_tens   = r_secs_tens;
    assign secs_ones   = r_secs_ones;
    assign digit_blank = w_blank;
    assign blink_on    = r_blink_on;
    assign scan_idx    = r_scan_idx;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against a seconds-based reference model.
module tb_stopwatch_ctrl;

    localparam int P_ONE   = 4;
    localparam int P_ADJ   = 3;
    localparam int P_BLINK = 2;
    localparam int P_SCAN  = 2;
    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_ADJ   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       pause_pulse = 1'b0;
    logic [3:0] mins_tens, mins_ones, secs_tens, secs_ones, digit_blank;
    logic       blink_on;
    logic [1:0] scan_idx;
    logic [22:0] obs;
    logic [15:0] digs;

    int total = 0;
    int bad   = 0;

    // Reference model: time as total seconds, mode, cycles spent in mode, cycles since reset.
    int m_time  = 0;
    int m_mode  = M_RUN;
    int m_run_n = 0;
    int m_adj_n = 0;
    int m_cyc   = 0;
    bit m_paused = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .ONE_HZ_DIV(P_ONE), .ADJ_DIV(P_ADJ), .BLINK_DIV(P_BLINK), .SCAN_DIV(P_SCAN)
    ) dut (
        .clk(clk), .rst(rst), .adj(adj), .sel(sel), .pause_pulse(pause_pulse),
        .mins_tens(mins_tens), .mins_ones(mins_ones),
        .secs_tens(secs_tens), .secs_ones(secs_ones),
        .digit_blank(digit_blank), .blink_on(blink_on), .scan_idx(scan_idx)
    );

    assign digs = {mins_tens, mins_ones, secs_tens, secs_ones};
    assign obs  = {digs, digit_blank, blink_on, scan_idx};

    function automatic logic [22:0] exp_out();
        int mm, ss;
        logic [3:0] bl;
        logic bo;
        logic [1:0] sc;
        mm = m_time / 60;
        ss = m_time % 60;
        bo = ((m_cyc / P_BLINK) % 2) == 0;
        sc = 2'((m_cyc / P_SCAN) % 4);
        bl = 4'b0000;
        if (m_mode == M_ADJ && !bo) bl = sel ? 4'b0011 : 4'b1100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), bl, bo, sc};
    endfunction

    task automatic m_step();
        bit t1, ta;
        if (rst) begin
            m_time = 0; m_mode = M_RUN; m_run_n = 0; m_adj_n = 0; m_cyc = 0; m_paused = 1'b0;
            return;
        end
        t1 = (m_mode == M_RUN) && (m_run_n % P_ONE == P_ONE - 1);
        ta = (m_mode == M_ADJ) && (m_adj_n % P_ADJ == P_ADJ - 1);
        if (t1) m_time = (m_time + 1) % 3600;
        if (ta) begin
            if (!sel) m_time = ((m_time / 60 + 1) % 60) * 60 + m_time % 60;
            else      m_time = (m_time / 60) * 60 + (m_time % 60 + 1) % 60;
        end
        m_run_n  = (m_mode == M_RUN) ? m_run_n + 1 : 0;
        m_adj_n  = (m_mode == M_ADJ) ? m_adj_n + 1 : 0;
        m_cyc    = m_cyc + 1;
        m_paused = m_paused ^ pause_pulse;
        m_mode   = adj ? M_ADJ : (m_paused ? M_PAUSE : M_RUN);
    endtask

    // One clock: advance the model with the applied inputs, then let the DUT take the edge.
    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        pause_pulse = 1'b0;
    endtask

    // Adjust-mode preload to mm:ss; leaves adj=1.
    task automatic preload(input int tm, input int ts);
        int n;
        n = 0;
        adj = 1'b1; sel = 1'b0;
        while ((m_time / 60) != tm && n < 400) begin cyc(); n++; end
        sel = 1'b1;
        while ((m_time % 60) != ts && n < 800) begin cyc(); n++; end
        total++;
        if (n >= 800) begin
            $display("FAIL preload_timeout: got %0d cycles, want < 800", n);
            bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; adj = 1'b0; sel = 1'b0; pause_pulse = 1'b0;
        cyc();
        total++;
        if (obs !== 23'h000004) begin
            $display("FAIL reset_state: got %h want %h", obs, 23'h000004); bad++;
        end
        rst = 1'b0;
    endtask

    task automatic test_count();
        int changes;
        logic [3:0] prev;
        changes = 0;
        prev = secs_ones;
        for (int i = 0; i < 240; i++) begin
            cyc();
            total++;
            if (obs !== exp_out()) begin
                $display("FAIL count_cycle%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
            if (secs_ones !== prev) changes++;
            prev = secs_ones;
        end
        total++;
        if (changes != 60) begin
            $display("FAIL count_changes: got %0d want 60", changes); bad++;
        end
        total++;
        if (digs !== 16'h0100) begin
            $display("FAIL count_final: got %h want 0100", digs); bad++;
        end
    endtask

    task automatic test_wrap();
        preload(59, 58);
        adj = 1'b0;
        cyc();
        total++;
        if (digs !== 16'h5958) begin
            $display("FAIL wrap_preload: got %h want 5958", digs); bad++;
        end
        for (int i = 1; i <= 8; i++) begin
            cyc();
            total++;
            if (obs !== exp_out()) begin
                $display("FAIL wrap_cycle%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
            if (i == 4) begin
                total++;
                if (digs !== 16'h5959) begin
                    $display("FAIL wrap_5959: got %h want 5959", digs); bad++;
                end
            end
        end
        total++;
        if (digs !== 16'h0000) begin
            $display("FAIL wrap_0000: got %h want 0000", digs); bad++;
        end
    endtask

    task automatic test_pause();
        pause_pulse = 1'b1;
        cyc();
        for (int i = 0; i < 40; i++) begin
            cyc();
            total++;
            if (obs !== exp_out() || digs !== 16'h0000) begin
                $display("FAIL pause_frozen%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
        end
        pause_pulse = 1'b1;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            total++;
            if (digs !== ((k == 4) ? 16'h0001 : 16'h0000)) begin
                $display("FAIL resume_k%0d: got %h want %h", k, digs,
                         (k == 4) ? 16'h0001 : 16'h0000); bad++;
            end
        end
    endtask

    task automatic test_adjust();
        pause_pulse = 1'b1;
        cyc();
        preload(12, 34);
        adj = 1'b0;
        cyc();
        total++;
        if (digs !== 16'h1234) begin
            $display("FAIL adjust_preload: got %h want 1234", digs); bad++;
        end
        adj = 1'b1; sel = 1'b0;
        cyc();
        for (int i = 0; i < 15; i++) begin
            if (i == 9) sel = 1'b1;
            cyc();
            total++;
            if (obs !== exp_out()) begin
                $display("FAIL adjust_cycle%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
            if (i == 8 || i == 14) begin
                total++;
                if (digs !== ((i == 8) ? 16'h1534 : 16'h1536)) begin
                    $display("FAIL adjust_step%0d: got %h want %h", i, digs,
                             (i == 8) ? 16'h1534 : 16'h1536); bad++;
                end
            end
        end
    endtask

    task automatic test_adjust_pause();
        pause_pulse = 1'b1;
        cyc();
        adj = 1'b0;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            total++;
            if (digs !== ((k == 4) ? 16'h1537 : 16'h1536)) begin
                $display("FAIL adjpause_run_k%0d: got %h want %h", k, digs,
                         (k == 4) ? 16'h1537 : 16'h1536); bad++;
            end
        end
        adj = 1'b1;
        cyc();
        pause_pulse = 1'b1;
        cyc();
        adj = 1'b0;
        cyc();
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (obs !== exp_out() || digs !== 16'h1537) begin
                $display("FAIL adjpause_frozen%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        preload(3, 26);
        adj = 1'b0;
        cyc();
        pause_pulse = 1'b1;
        cyc();
        n = 0;
        while (!(m_mode == M_RUN && m_time == 207 && (m_run_n % P_ONE) == P_ONE - 1) && n < 40) begin
            cyc();
            n++;
        end
        total++;
        if (digs !== 16'h0327) begin
            $display("FAIL rstmid_pre: got %h want 0327 (waited %0d)", digs, n); bad++;
        end
        rst = 1'b1;
        cyc();
        total++;
        if (obs !== 23'h000004) begin
            $display("FAIL rstmid_state: got %h want %h", obs, 23'h000004); bad++;
        end
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) cyc();
        pause_pulse = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (digs !== 16'h0001) begin
                $display("FAIL simul_pause%0d: got %h want 0001", i, digs); bad++;
            end
            cyc();
        end
        pause_pulse = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        adj = 1'b1; sel = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs !== exp_out() || digs !== 16'h0002) begin
                $display("FAIL simul_adj%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
            cyc();
        end
        adj = 1'b0;
        cyc();
        total++;
        if (obs !== exp_out()) begin
            $display("FAIL simul_exit: got %h want %h", obs, exp_out()); bad++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) adj = ~adj;
            if ($urandom_range(0, 6) == 0) sel = ~sel;
            pause_pulse = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 399) == 0);
            cyc();
            total++;
            if (obs !== exp_out()) begin
                $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_out()); bad++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adjust();
        test_adjust_pause();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
